kmeans_assign_pipe: RTL and testbench
=====================================

Name: kmeans_assign_pipe

Overview:
- Sequential, parametrised successor to the combinational nearest-centroid unit in the k-means accelerator.
- Accepts one point per transaction over a valid/ready handshake and scans K centroids, P at a time, over K/P beats.
- Tracks a running minimum as it scans, then returns the winning cluster index and its distance over an output valid/ready handshake.
- Supports squared-Euclidean and Manhattan metrics; sits between the point streamer and the centroid-update accumulator.

Parameters:
- K, 8, number of centroids; K >= 2; K % P == 0.
- D, 4, point dimensionality; D >= 1.
- W, 8, signed coordinate width.
- P, 2, centroids evaluated per beat (parallel lanes).
- Derived: CW = max(1, clog2(K)); NB = K/P beats; DW = 2W+2+clog2(D) when D > 1, else 2W+2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  point_flat and mode are valid.
- in_ready  out  1  unit can accept a point this cycle.
- point_flat  in  D*W  signed coordinates; coordinate j at [j*W +: W].
- mode  in  1  0 = squared Euclidean, 1 = Manhattan (L1).
- centroid_flat  in  K*D*W  signed; centroid i, coordinate j at [(i*D+j)*W +: W].
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_cluster  out  CW  index of the nearest centroid.
- out_dist  out  DW  unsigned distance to that centroid.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, out_cluster=0, out_dist=0, beat counter 0.
- Reset mid-operation aborts the point in flight; no result is emitted for it.
- FSM states are IDLE, RUN and DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Ready is combinational from out_ready.
- IDLE: on in_valid & in_ready, latch point_flat and mode, set beat=0, clear the running minimum, go to RUN.
- RUN, each cycle:
  - Lane l (l = 0..P-1) processes centroid c = beat*P + l.
  - diff_j = point_j - centroid_c,j, computed at W+1 bits signed.
  - Mode 0: term = diff_j * diff_j, 2W+2 bits unsigned. Mode 1: term = |diff_j|.
  - The D terms are summed at DW bits; no overflow or saturation is possible.
  - Combine lanes, then the register, using strict less-than. Ties go to the lower centroid index: lower lane beats higher lane, and an earlier beat beats a later one.
  - Registered minimum: best_dist / best_idx.
  - beat increments each cycle. On beat==NB-1, write the final result into out_cluster/out_dist, set out_valid=1, go to DONE.
- Latency: acceptance edge to out_valid asserted is exactly NB cycles (K=8, P=2 gives 4). For P==K, NB=1.
- DONE: out_cluster/out_dist are held stable while out_valid=1 & !out_ready.
  - On out_ready: clear out_valid. If in_valid on the same cycle, accept the new point and go to RUN (back-to-back, no bubble); otherwise go to IDLE.
  - Sustained throughput is one point per NB+1 cycles.
- centroid_flat is sampled live every RUN beat. It must be held stable from acceptance until out_valid. The unit does not check this.
- mode is used only as latched; changes after acceptance have no effect.
- out_valid is never asserted in IDLE or RUN. in_ready is 0 throughout RUN.
- out_cluster/out_dist retain their last values after handshake until the next result is written.

Test Plan:
- Reset and basic metric: K=8, D=4, W=8, P=2; centroid i has all coords 10*i; point all 25, mode 0, out_ready=1. Required response:
  - out_valid exactly 4 cycles after acceptance.
  - out_cluster=2, out_dist=100, because c2 and c3 tie and the lower index wins.
  - in_ready=0 during the 4 RUN cycles.
- Manhattan: same centroids, point all 25, mode=1 -> out_cluster=2, out_dist=20. Point all 61, mode=1 -> out_cluster=6, out_dist=4.
- Extreme values: point all -128, every centroid all 127, mode 0 -> out_cluster=0, out_dist=260100, with no wrap. Point equal to c5 -> out_cluster=5, out_dist=0.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid: outputs are stable and in_ready=0.
  - Then raise out_ready with in_valid=1: the next point is accepted on the same edge, and its result appears 4 cycles later.
  - Stream 20 random points and compare against a reference argmin model.
- Reset mid-RUN: assert rst_n=0 at beat 2. Required response:
  - out_valid=0, in_ready=1 and out_dist=0 immediately (asynchronous).
  - After release, a new point produces the correct result with no stale minimum.
- Parameter sweep: the (K,P,D) sets (8,8,4), (8,1,4), (6,3,3) and (4,2,1) give latencies NB = 1, 8, 2 and 2 respectively. Ties always resolve to the lowest index.

Source files
------------

// File: rtl/kmeans_assign_pipe.sv
// kmeans_assign_pipe: sequential nearest-centroid search for the k-means accelerator.
// A point is accepted over a valid/ready handshake. The K centroids are then scanned
// P per beat over K/P beats while a running minimum is kept. The winning index and its
// distance are presented over an output valid/ready handshake. Squared-Euclidean
// (mode 0) and Manhattan (mode 1) metrics are supported.
module kmeans_assign_pipe #(
  parameter  int K  = 8,
  parameter  int D  = 4,
  parameter  int W  = 8,
  parameter  int P  = 2,
  localparam int CW = (K > 1) ? $clog2(K) : 1,
  localparam int DW = (D > 1) ? (2*W + 2 + $clog2(D)) : (2*W + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D*W-1:0]    point_flat,
  input  logic              mode,
  input  logic [K*D*W-1:0]  centroid_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_cluster,
  output logic [DW-1:0]     out_dist
);

  localparam int NB = K / P;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [D*W-1:0]  point_q;
  logic            mode_q;
  logic [BW-1:0]   beat;
  logic [DW-1:0]   best_dist;
  logic [CW-1:0]   best_idx;
  logic [DW-1:0]   cand_dist, next_dist;
  logic [CW-1:0]   cand_idx, next_idx;
  logic            accept;
  logic            last_beat;

  // Distance from the point to one centroid. Coordinate differences are taken at W+1
  // bits so the full signed range cannot wrap, and the sum width DW leaves headroom for D terms.
  function automatic logic [DW-1:0] lane_distance(input logic [D*W-1:0] p,
                                                  input logic [D*W-1:0] c,
                                                  input logic           m);
    logic signed [W:0]     diff;
    logic signed [2*W+1:0] wide;
    logic [2*W+1:0]        term;
    logic [DW-1:0]         acc;
    acc = '0;
    for (int j = 0; j < D; j++) begin
      diff = $signed({p[j*W+W-1], p[j*W +: W]}) - $signed({c[j*W+W-1], c[j*W +: W]});
      wide = {{(W+1){diff[W]}}, diff};
      if (m) begin
        term = {{(W+1){1'b0}}, (diff[W] ? -diff : diff)};
      end else begin
        term = wide * wide;
      end
      acc = acc + DW'(term);
    end
    return acc;
  endfunction

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last_beat = (beat == BW'(NB - 1));

  // Evaluate this beat's P lanes, keep the lowest-index strict winner, then merge it with the running minimum.
  always_comb begin
    int base;
    logic [DW-1:0] d;
    d    = '0;
    base = int'(beat) * P;
    cand_dist = lane_distance(point_q, centroid_flat[base*D*W +: D*W], mode_q);
    cand_idx  = CW'(base);
    for (int l = 1; l < P; l++) begin
      d = lane_distance(point_q, centroid_flat[(base+l)*D*W +: D*W], mode_q);
      if (d < cand_dist) begin
        cand_dist = d;
        cand_idx  = CW'(base + l);
      end
    end
    next_dist = best_dist;
    next_idx  = best_idx;
    if ((beat == '0) || (cand_dist < best_dist)) begin
      next_dist = cand_dist;
      next_idx  = cand_idx;
    end
  end

  // Next-state logic: DONE can hand straight over to RUN when a new point is waiting.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (last_beat) state_n = DONE;
      DONE: if (out_ready) state_n = accept ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers: latch the point on acceptance, track the minimum while running, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      point_q     <= '0;
      mode_q      <= 1'b0;
      beat        <= '0;
      best_dist   <= '0;
      best_idx    <= '0;
      out_valid   <= 1'b0;
      out_cluster <= '0;
      out_dist    <= '0;
    end else begin
      if (state == RUN) begin
        best_dist <= next_dist;
        best_idx  <= next_idx;
        if (last_beat) begin
          beat        <= '0;
          out_cluster <= next_idx;
          out_dist    <= next_dist;
          out_valid   <= 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        point_q   <= point_flat;
        mode_q    <= mode;
        beat      <= '0;
        best_dist <= '1;
        best_idx  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_kmeans_assign_pipe.sv
// tb_kmeans_assign_pipe: scoreboard bench for the nearest-centroid pipeline.
// Stimulus pushes the hand-computed (or reference-model) result into a queue, and a
// monitor pops and compares whenever the DUT completes an output handshake. A second
// group of DUT instances covers the alternate (K,P,D) configurations.
module tb_kmeans_assign_pipe;

  localparam int K  = 8;
  localparam int D  = 4;
  localparam int W  = 8;
  localparam int P  = 2;
  localparam int CW = 3;
  localparam int DW = 20;

  typedef struct {
    int c;
    int d;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [D*W-1:0]   point_flat;
  logic             mode;
  logic [K*D*W-1:0] centroid_flat;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_cluster;
  logic [DW-1:0]    out_dist;

  // Shared controls plus per-instance signals for the configuration sweep.
  logic             sw_valid;
  logic             sw_mode;
  logic             sw_oready;
  logic             s0_ready, s0_ovalid;
  logic [31:0]      s0_point;
  logic [255:0]     s0_cent;
  logic [2:0]       s0_cl;
  logic [19:0]      s0_d;
  logic             s1_ready, s1_ovalid;
  logic [31:0]      s1_point;
  logic [255:0]     s1_cent;
  logic [2:0]       s1_cl;
  logic [19:0]      s1_d;
  logic             s2_ready, s2_ovalid;
  logic [23:0]      s2_point;
  logic [143:0]     s2_cent;
  logic [2:0]       s2_cl;
  logic [19:0]      s2_d;
  logic             s3_ready, s3_ovalid;
  logic [7:0]       s3_point;
  logic [31:0]      s3_cent;
  logic [1:0]       s3_cl;
  logic [17:0]      s3_d;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  kmeans_assign_pipe #(.K(K), .D(D), .W(W), .P(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .point_flat(point_flat), .mode(mode), .centroid_flat(centroid_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_cluster(out_cluster), .out_dist(out_dist)
  );

  kmeans_assign_pipe #(.K(8), .D(4), .W(8), .P(8)) sw0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s0_ready),
    .point_flat(s0_point), .mode(sw_mode), .centroid_flat(s0_cent),
    .out_valid(s0_ovalid), .out_ready(sw_oready), .out_cluster(s0_cl), .out_dist(s0_d)
  );

  kmeans_assign_pipe #(.K(8), .D(4), .W(8), .P(1)) sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_ready),
    .point_flat(s1_point), .mode(sw_mode), .centroid_flat(s1_cent),
    .out_valid(s1_ovalid), .out_ready(sw_oready), .out_cluster(s1_cl), .out_dist(s1_d)
  );

  kmeans_assign_pipe #(.K(6), .D(3), .W(8), .P(3)) sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s2_ready),
    .point_flat(s2_point), .mode(sw_mode), .centroid_flat(s2_cent),
    .out_valid(s2_ovalid), .out_ready(sw_oready), .out_cluster(s2_cl), .out_dist(s2_d)
  );

  kmeans_assign_pipe #(.K(4), .D(1), .W(8), .P(2)) sw3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s3_ready),
    .point_flat(s3_point), .mode(sw_mode), .centroid_flat(s3_cent),
    .out_valid(s3_ovalid), .out_ready(sw_oready), .out_cluster(s3_cl), .out_dist(s3_d)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so a wedged DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  // Build a point with every coordinate equal to v.
  function automatic logic [D*W-1:0] splat(input int v);
    logic [D*W-1:0] r;
    for (int j = 0; j < D; j++) r[j*W +: W] = W'(v);
    return r;
  endfunction

  // Centroid i gets every coordinate equal to 10*i.
  task automatic setCentroidsRamp();
    for (int i = 0; i < K; i++)
      for (int j = 0; j < D; j++)
        centroid_flat[(i*D+j)*W +: W] = W'(10*i);
  endtask

  // Every centroid gets every coordinate equal to v.
  task automatic setCentroidsAll(input int v);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < D; j++)
        centroid_flat[(i*D+j)*W +: W] = W'(v);
  endtask

  // Brute-force argmin over all centroids, lowest index wins on ties.
  task automatic refModel(input logic [D*W-1:0] p, input logic m, output int ci, output int cd);
    int dsum;
    int df;
    ci = 0;
    cd = 0;
    for (int i = 0; i < K; i++) begin
      dsum = 0;
      for (int j = 0; j < D; j++) begin
        df = int'($signed(p[j*W +: W])) - int'($signed(centroid_flat[(i*D+j)*W +: W]));
        dsum += m ? ((df < 0) ? -df : df) : df * df;
      end
      if (i == 0 || dsum < cd) begin
        ci = i;
        cd = dsum;
      end
    end
  endtask

  // Offer a point, wait (bounded) for acceptance, record the expected result, then scramble the inputs.
  task automatic applyStimulus(input logic [D*W-1:0] p, input logic m, input int ec, input int ed);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", int'(in_ready), 1);
      return;
    end
    point_flat = p;
    mode       = m;
    in_valid   = 1'b1;
    e.c = ec;
    e.d = ed;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    point_flat = ~p;
    mode       = ~m;
  endtask

  // Count edges from acceptance to out_valid and confirm in_ready stays low meanwhile.
  task automatic measureLatency(input int expLat);
    int n;
    int readyBad;
    n = 0;
    readyBad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
      if (in_ready) readyBad++;
    end
    checkOutput("latency", n, expLat);
    checkOutput("in_ready_during_run", readyBad, 0);
  endtask

  // Wait (bounded) until the unit is idle and every expected result has been consumed.
  task automatic waitIdle();
    int ok;
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      if (in_ready && !out_valid && sb.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("reach_idle", ok, 1);
  endtask

  // Monitor: pop and compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out_valid", int'(out_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_cluster", int'(out_cluster), mon_e.c);
        checkOutput("out_dist", int'(out_dist), mon_e.d);
      end
    end
  end

  // Main directed sequence.
  initial begin
    int rc, rd;
    int holdBad, holdReady;
    logic [CW-1:0] hc;
    logic [DW-1:0] hd;
    logic [D*W-1:0] rp;
    logic rm;
    int sweepLat[4];
    int sweepC[4];
    int sweepD[4];
    int expLat[4];
    int expD[4];

    rst_n      = 1'b1;
    in_valid   = 1'b0;
    mode       = 1'b0;
    point_flat = '0;
    out_ready  = 1'b1;
    sw_valid   = 1'b0;
    sw_mode    = 1'b0;
    sw_oready  = 1'b1;
    setCentroidsRamp();
    for (int i = 0; i < 8; i++) for (int j = 0; j < 4; j++) s0_cent[(i*4+j)*8 +: 8] = 8'(10*i);
    for (int i = 0; i < 8; i++) for (int j = 0; j < 4; j++) s1_cent[(i*4+j)*8 +: 8] = 8'(10*i);
    for (int i = 0; i < 6; i++) for (int j = 0; j < 3; j++) s2_cent[(i*3+j)*8 +: 8] = 8'(10*i);
    for (int i = 0; i < 4; i++) s3_cent[i*8 +: 8] = 8'(10*i);
    for (int j = 0; j < 4; j++) s0_point[j*8 +: 8] = 8'd15;
    for (int j = 0; j < 4; j++) s1_point[j*8 +: 8] = 8'd15;
    for (int j = 0; j < 3; j++) s2_point[j*8 +: 8] = 8'd15;
    s3_point = 8'd15;

    #2 rst_n = 1'b0;
    #10;
    $display("[TB] checking reset state");
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_cluster", int'(out_cluster), 0);
    checkOutput("reset_out_dist", int'(out_dist), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] squared Euclidean with a tie between c2 and c3");
    applyStimulus(splat(25), 1'b0, 2, 100);
    measureLatency(4);
    waitIdle();

    $display("[TB] Manhattan metric");
    applyStimulus(splat(25), 1'b1, 2, 20);
    waitIdle();
    applyStimulus(splat(61), 1'b1, 6, 4);
    waitIdle();

    $display("[TB] extreme coordinates");
    setCentroidsAll(127);
    applyStimulus(splat(-128), 1'b0, 0, 260100);
    waitIdle();
    setCentroidsRamp();
    applyStimulus(splat(50), 1'b0, 5, 0);
    waitIdle();

    $display("[TB] backpressure then back-to-back acceptance");
    out_ready = 1'b0;
    applyStimulus(splat(25), 1'b0, 2, 100);
    measureLatency(4);
    hc = out_cluster;
    hd = out_dist;
    holdBad = 0;
    holdReady = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (!out_valid || out_cluster != hc || out_dist != hd) holdBad++;
      if (in_ready) holdReady++;
    end
    checkOutput("hold_stable", holdBad, 0);
    checkOutput("hold_in_ready", holdReady, 0);
    point_flat = splat(61);
    mode       = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    mon_e.c = 6;
    mon_e.d = 4;
    sb.push_back(mon_e);
    #1;
    checkOutput("b2b_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    measureLatency(4);
    waitIdle();

    $display("[TB] random stream against the reference argmin");
    for (int i = 0; i < K; i++)
      for (int j = 0; j < D; j++)
        centroid_flat[(i*D+j)*W +: W] = W'($urandom_range(0, 255));
    for (int n = 0; n < 20; n++) begin
      for (int j = 0; j < D; j++) rp[j*W +: W] = W'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      refModel(rp, rm, rc, rd);
      applyStimulus(rp, rm, rc, rd);
    end
    waitIdle();
    setCentroidsRamp();

    $display("[TB] reset in the middle of a scan");
    applyStimulus(splat(25), 1'b0, 2, 100);
    waitIdle();
    applyStimulus(splat(25), 1'b0, 2, 100);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_in_ready", int'(in_ready), 1);
    checkOutput("midreset_out_dist", int'(out_dist), 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(splat(-100), 1'b0, 0, 40000);
    measureLatency(4);
    waitIdle();

    $display("[TB] configuration sweep");
    expLat = '{1, 8, 2, 2};
    expD   = '{100, 100, 75, 25};
    for (int s = 0; s < 4; s++) begin
      sweepLat[s] = -1;
      sweepC[s]   = -1;
      sweepD[s]   = -1;
    end
    sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (sweepLat[0] < 0 && s0_ovalid) begin sweepLat[0] = cyc; sweepC[0] = int'(s0_cl); sweepD[0] = int'(s0_d); end
      if (sweepLat[1] < 0 && s1_ovalid) begin sweepLat[1] = cyc; sweepC[1] = int'(s1_cl); sweepD[1] = int'(s1_d); end
      if (sweepLat[2] < 0 && s2_ovalid) begin sweepLat[2] = cyc; sweepC[2] = int'(s2_cl); sweepD[2] = int'(s2_d); end
      if (sweepLat[3] < 0 && s3_ovalid) begin sweepLat[3] = cyc; sweepC[3] = int'(s3_cl); sweepD[3] = int'(s3_d); end
    end
    for (int s = 0; s < 4; s++) begin
      checkOutput($sformatf("sweep%0d_latency", s), sweepLat[s], expLat[s]);
      checkOutput($sformatf("sweep%0d_cluster", s), sweepC[s], 1);
      checkOutput($sformatf("sweep%0d_dist", s), sweepD[s], expD[s]);
    end

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
